mem_arbiter: RTL and testbench

//  Shares one single-port synchronous RAM between the core's instruction-fetch port (I) and

---
 rtl/mem_arbiter.sv | 149 ++++++++++++++
 tb/tb_mem_arbiter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port synchronous RAM between the instruction-fetch (I)
// and data (D) ports of the core. One access per cycle with a combinational grant. On a
// conflict the port that was not granted last wins. Read data comes back one cycle later
// and is steered to the port that issued the read. A saturating counter records every
// cycle in which both ports requested.
module mem_arbiter #(
   parameter int AW = 32,
   parameter int MW = 14,
   parameter int CW = 32
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          i_req,
   input  logic [AW-1:0] i_addr,
   output logic          i_gnt,
   output logic          i_rvalid,
   output logic [31:0]   i_rdata,
   input  logic          d_req,
   input  logic          d_we,
   input  logic [3:0]    d_be,
   input  logic [AW-1:0] d_addr,
   input  logic [31:0]   d_wdata,
   output logic          d_gnt,
   output logic          d_rvalid,
   output logic [31:0]   d_rdata,
   output logic          m_en,
   output logic          m_we,
   output logic [3:0]    m_be,
   output logic [MW-1:0] m_addr,
   output logic [31:0]   m_wdata,
   input  logic [31:0]   m_rdata,
   output logic [CW-1:0] conflicts
);

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_I    = 2'd1,
      OWN_D    = 2'd2
   } owner_t;

   owner_t          rd_owner_r;
   owner_t          rd_owner_next_s;
   logic            last_gnt_d_r;   // 1: most recent grant went to D
   logic            last_gnt_d_next_s;
   logic [CW-1:0]   conflicts_r;
   logic [CW-1:0]   conflicts_next_s;
   logic            i_gnt_s;
   logic            d_gnt_s;
   logic            both_req_s;

   // Address bits outside the RAM word index carry no meaning here.
   logic unused_addr_bits_s;
   assign unused_addr_bits_s = ^{i_addr[AW-1:MW+2], i_addr[1:0],
                                 d_addr[AW-1:MW+2], d_addr[1:0]};

   assign both_req_s = i_req & d_req;

   // Arbitration: single requester wins outright, a tie goes to the port not granted last.
   always_comb begin
      i_gnt_s = 1'b0;
      d_gnt_s = 1'b0;
      if (reset) begin
         i_gnt_s = 1'b0;
         d_gnt_s = 1'b0;
      end else if (both_req_s) begin
         if (last_gnt_d_r) begin
            i_gnt_s = 1'b1;
         end else begin
            d_gnt_s = 1'b1;
         end
      end else if (i_req) begin
         i_gnt_s = 1'b1;
      end else if (d_req) begin
         d_gnt_s = 1'b1;
      end else begin
         i_gnt_s = 1'b0;
         d_gnt_s = 1'b0;
      end
   end

   // RAM command built from whichever port holds the grant this cycle.
   always_comb begin
      m_en    = i_gnt_s | d_gnt_s;
      m_we    = 1'b0;
      m_be    = 4'b0000;
      m_addr  = i_addr[MW+1:2];
      m_wdata = d_wdata;
      if (d_gnt_s) begin
         m_addr = d_addr[MW+1:2];
         if (d_we) begin
            m_we = 1'b1;
            m_be = d_be;
         end else begin
            m_we = 1'b0;
            m_be = 4'b0000;
         end
      end else begin
         m_addr = i_addr[MW+1:2];
      end
   end

   // Next-state for read owner, round-robin pointer and saturating conflict counter.
   always_comb begin
      rd_owner_next_s   = OWN_NONE;
      last_gnt_d_next_s = last_gnt_d_r;
      conflicts_next_s  = conflicts_r;
      if (i_gnt_s) begin
         rd_owner_next_s   = OWN_I;
         last_gnt_d_next_s = 1'b0;
      end else if (d_gnt_s) begin
         last_gnt_d_next_s = 1'b1;
         if (d_we) begin
            rd_owner_next_s = OWN_NONE;
         end else begin
            rd_owner_next_s = OWN_D;
         end
      end else begin
         rd_owner_next_s   = OWN_NONE;
         last_gnt_d_next_s = last_gnt_d_r;
      end
      if (both_req_s && (conflicts_r != {CW{1'b1}})) begin
         conflicts_next_s = conflicts_r + {{(CW-1){1'b0}}, 1'b1};
      end else begin
         conflicts_next_s = conflicts_r;
      end
   end

   // State register; reset drops any outstanding read and lets I win the first tie.
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_owner_r   <= OWN_NONE;
         last_gnt_d_r <= 1'b1;
         conflicts_r  <= {CW{1'b0}};
      end else begin
         rd_owner_r   <= rd_owner_next_s;
         last_gnt_d_r <= last_gnt_d_next_s;
         conflicts_r  <= conflicts_next_s;
      end
   end

   assign i_gnt     = i_gnt_s;
   assign d_gnt     = d_gnt_s;
   assign i_rvalid  = ~reset & (rd_owner_r == OWN_I);
   assign d_rvalid  = ~reset & (rd_owner_r == OWN_D);
   assign i_rdata   = m_rdata;
   assign d_rdata   = m_rdata;
   assign conflicts = conflicts_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a RAM model driven by the DUT's m_* port, a reference model of
// the arbitration rules checked every cycle on the falling edge, and directed scenarios
// with hand-computed literal expectations.
module tb_mem_arbiter;
   localparam int AW = 32;
   localparam int MW = 14;
   localparam int CW = 5;
   localparam int CMAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          reset;
   logic          i_req, d_req, d_we;
   logic [AW-1:0] i_addr, d_addr;
   logic [3:0]    d_be;
   logic [31:0]   d_wdata;
   logic          i_gnt, i_rvalid, d_gnt, d_rvalid;
   logic [31:0]   i_rdata, d_rdata;
   logic          m_en, m_we;
   logic [3:0]    m_be;
   logic [MW-1:0] m_addr;
   logic [31:0]   m_wdata, m_rdata;
   logic [CW-1:0] conflicts;

   int checks = 0;
   int failures = 0;
   bit model_on = 1'b0;

   mem_arbiter #(.AW(AW), .MW(MW), .CW(CW)) dut (
      .clk(clk), .reset(reset),
      .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
      .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .m_en(m_en), .m_we(m_we), .m_be(m_be), .m_addr(m_addr), .m_wdata(m_wdata),
      .m_rdata(m_rdata), .conflicts(conflicts)
   );

   always #5 clk = ~clk;

   // RAM attached to the DUT: one-cycle read latency, byte-enabled writes.
   logic [31:0] ram [0:(1<<MW)-1];
   always @(posedge clk) begin
      if (m_en) begin
         if (m_we) begin
            for (int b = 0; b < 4; b++)
               if (m_be[b]) ram[m_addr][8*b +: 8] <= m_wdata[8*b +: 8];
         end else begin
            m_rdata <= ram[m_addr];
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model state, expressed in terms of the rules, not the RTL structure.
   logic [31:0] ref_mem [0:(1<<MW)-1];
   bit          last_was_i;       // most recent grant went to I
   int          pend_port;        // 0 none, 1 I, 2 D: port owed read data this cycle
   logic [31:0] pend_data;
   int          ref_cnt;

   function automatic int widx(input logic [AW-1:0] a);
      return int'(a[MW+1:2]);
   endfunction

   // Per-cycle comparison against the model, then advance the model to the next edge.
   always @(negedge clk) begin
      bit ei, ed;
      if (model_on) begin
         ei = 1'b0; ed = 1'b0;
         if (!reset) begin
            if (i_req && d_req) begin
               ei = !last_was_i; ed = last_was_i;
            end else begin
               ei = i_req; ed = d_req;
            end
         end
         chk("i_gnt", {31'd0, i_gnt}, {31'd0, ei});
         chk("d_gnt", {31'd0, d_gnt}, {31'd0, ed});
         chk("m_en", {31'd0, m_en}, {31'd0, ei | ed});
         if (ei | ed) begin
            chk("m_we", {31'd0, m_we}, {31'd0, ed & d_we});
            chk("m_be", {28'd0, m_be}, {28'd0, (ed & d_we) ? d_be : 4'b0000});
            chk("m_addr", 32'(m_addr), 32'(widx(ed ? d_addr : i_addr)));
            if (ed & d_we) chk("m_wdata", m_wdata, d_wdata);
         end
         chk("i_rvalid", {31'd0, i_rvalid}, {31'd0, (!reset && pend_port == 1)});
         chk("d_rvalid", {31'd0, d_rvalid}, {31'd0, (!reset && pend_port == 2)});
         if (!reset && pend_port == 1) chk("i_rdata", i_rdata, pend_data);
         if (!reset && pend_port == 2) chk("d_rdata", d_rdata, pend_data);
         chk("conflicts", 32'(conflicts), 32'(ref_cnt));
      end
      // advance to the state after the coming rising edge
      if (reset) begin
         last_was_i = 1'b0; pend_port = 0; ref_cnt = 0;
      end else begin
         bit gi, gd;
         gi = i_req && (!d_req || !last_was_i);
         gd = d_req && !gi;
         pend_port = 0;
         if (gi) begin
            last_was_i = 1'b1; pend_port = 1; pend_data = ref_mem[widx(i_addr)];
         end else if (gd) begin
            last_was_i = 1'b0;
            if (d_we) begin
               for (int b = 0; b < 4; b++)
                  if (d_be[b]) ref_mem[widx(d_addr)][8*b +: 8] = d_wdata[8*b +: 8];
            end else begin
               pend_port = 2; pend_data = ref_mem[widx(d_addr)];
            end
         end
         if (i_req && d_req && ref_cnt < CMAX) ref_cnt++;
      end
   end

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic idle();
      i_req = 1'b0; d_req = 1'b0; d_we = 1'b0; d_be = 4'b0000;
      i_addr = '0; d_addr = '0; d_wdata = 32'd0;
   endtask

   task automatic do_reset();
      reset = 1'b1; step(); reset = 1'b0;
   endtask

   initial begin
      for (int k = 0; k < (1 << MW); k++) begin
         ram[k] = {16'hC0DE, 16'(k)};
         ref_mem[k] = {16'hC0DE, 16'(k)};
      end
      m_rdata = 32'd0;
      idle();
      reset = 1'b1;
      i_req = 1'b1; d_req = 1'b1;      // requests ignored while reset is high
      step(); model_on = 1'b1;
      step(); idle(); reset = 1'b0;

      // 1: lone fetch; upper address bits ignored
      i_req = 1'b1; i_addr = 32'hFFFF_0010; #3;
      chk("t1_i_gnt", {31'd0, i_gnt}, 32'd1);
      chk("t1_m_addr", 32'(m_addr), 32'd4);
      step(); idle(); #3;
      chk("t1_i_rvalid", {31'd0, i_rvalid}, 32'd1);
      chk("t1_i_rdata", i_rdata, 32'hC0DE_0004);

      // 2: both from reset, I wins first
      do_reset();
      i_req = 1'b1; i_addr = 32'h0; d_req = 1'b1; d_addr = 32'h8; #3;
      chk("t2_c0_i_gnt", {31'd0, i_gnt}, 32'd1);
      step(); i_req = 1'b0; #3;
      chk("t2_c1_d_gnt", {31'd0, d_gnt}, 32'd1);
      chk("t2_c1_i_rvalid", {31'd0, i_rvalid}, 32'd1);
      step(); idle(); #3;
      chk("t2_c2_d_rvalid", {31'd0, d_rvalid}, 32'd1);
      chk("t2_d_rdata", d_rdata, 32'hC0DE_0002);
      chk("t2_conflicts", 32'(conflicts), 32'd1);

      // 3: six cycles of contention alternate I,D,...
      do_reset();
      i_req = 1'b1; i_addr = 32'h40; d_req = 1'b1; d_addr = 32'h44;
      for (int c = 0; c < 6; c++) begin
         #3;
         chk("t3_i_gnt", {31'd0, i_gnt}, (c % 2 == 0) ? 32'd1 : 32'd0);
         step();
      end
      idle(); #3;
      chk("t3_conflicts", 32'(conflicts), 32'd6);

      // 4: byte write then fetch of the same word
      step();
      d_req = 1'b1; d_we = 1'b1; d_be = 4'b0001; d_addr = 32'h20; d_wdata = 32'h0000_00AB; #3;
      chk("t4_m_we", {31'd0, m_we}, 32'd1);
      chk("t4_m_be", {28'd0, m_be}, 32'h1);
      chk("t4_m_addr", 32'(m_addr), 32'd8);
      step(); idle(); i_req = 1'b1; i_addr = 32'h20; #3;
      chk("t4_no_d_rvalid", {31'd0, d_rvalid}, 32'd0);
      step(); idle(); #3;
      chk("t4_i_rdata", i_rdata, 32'hC0DE_00AB);

      // 5: reset right after a granted D read
      d_req = 1'b1; d_addr = 32'h30; step();
      idle(); reset = 1'b1; #3;
      chk("t5_rvalid_in_reset", {31'd0, d_rvalid}, 32'd0);
      step(); reset = 1'b0; #3;
      chk("t5_rvalid_after", {31'd0, d_rvalid}, 32'd0);
      chk("t5_conflicts", 32'(conflicts), 32'd0);
      i_req = 1'b1; d_req = 1'b1; d_addr = 32'h30; #3;
      chk("t5_tie_to_i", {31'd0, i_gnt}, 32'd1);
      step();
      // D withdraws before its grant: no access
      idle(); #3;
      chk("t5_withdraw_m_en", {31'd0, m_en}, 32'd0);
      step();

      // 6: saturation of the conflict counter
      do_reset();
      i_req = 1'b1; i_addr = 32'h100; d_req = 1'b1; d_addr = 32'h104;
      for (int c = 0; c < CMAX - 1; c++) step();
      #3; chk("t6_almost", 32'(conflicts), 32'(CMAX - 1));
      for (int c = 0; c < 3; c++) step();
      idle(); #3;
      chk("t6_saturated", 32'(conflicts), 32'(CMAX));
      step(); step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Global time bound so the run always ends.
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end
endmodule
